// File: rtl/sc64_uart_link.sv
// sc64_uart_link: 8N1 console UART, TX FIFO + shifter, RX sampler + holding reg; UART_FLOW_CONTROL_EN adds CTS/RTS.
// Latency: txd falls 1 cycle after pop, RX input 2-cycle sync; tx_ready low when FIFO full, RX overrun drops the new byte.
`timescale 1ns/1ps

module sc64_uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rdata = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= wdata;
  end
endmodule

module sc64_uart_link #(
  parameter int CLOCK_FREQUENCY = 100_000_000,
  parameter int UART_BAUD_RATE  = 1_000_000,
  parameter int TX_FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_overrun,
  output logic       rx_frame_err,
  input  logic       err_clear,
  output logic       uart_txd,
  input  logic       uart_rxd,
  input  logic       uart_cts_n,
  output logic       uart_rts_n
);
  localparam int DIV = CLOCK_FREQUENCY / UART_BAUD_RATE;
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2 - 1);

  if (DIV < 4) begin : g_bad_div
    $error("sc64_uart_link: CLOCK_FREQUENCY/UART_BAUD_RATE must be at least 4");
  end
  if (TX_FIFO_DEPTH < 2 || TX_FIFO_DEPTH > 16 || (TX_FIFO_DEPTH & (TX_FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sc64_uart_link: TX_FIFO_DEPTH must be a power of two in 2..16");
  end

  logic cts_ok;
`ifdef UART_FLOW_CONTROL_EN
  logic [1:0] cts_sync;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cts_sync <= 2'b11;
    else          cts_sync <= {cts_sync[0], uart_cts_n};
  end
  assign cts_ok     = !cts_sync[1];
  assign uart_rts_n = rx_valid;
`else
  logic unused_cts;
  assign unused_cts = uart_cts_n;
  assign cts_ok     = 1'b1;
  assign uart_rts_n = 1'b0;
`endif

  // ---------------- TX ----------------
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  tx_state_t     tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shreg;
  logic          tx_last;
  logic          tx_pop;
  logic          tx_push;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_rdata;

  assign tx_last  = (tx_cnt == CNT_LAST);
  // Popping at the end of STOP keeps consecutive frames gap-free.
  assign tx_pop   = !fifo_empty && cts_ok &&
                    ((tx_state == TX_IDLE) || (tx_state == TX_STOP && tx_last));
  assign tx_ready = !fifo_full || tx_pop;
  assign tx_push  = tx_valid && tx_ready;
  assign tx_busy  = !fifo_empty || (tx_state != TX_IDLE);

  sc64_uart_fifo #(.WIDTH(8), .DEPTH(TX_FIFO_DEPTH)) u_tx_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (tx_push),
    .pop    (tx_pop),
    .wdata  (tx_data),
    .rdata  (fifo_rdata),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shreg <= '0;
      uart_txd <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          tx_cnt <= '0;
          if (tx_pop) begin
            tx_shreg <= fifo_rdata;
            uart_txd <= 1'b0;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_last) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            uart_txd <= tx_shreg[0];
            tx_state <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_last) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
              uart_txd <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              tx_bit   <= tx_bit + 1'b1;
              tx_shreg <= {1'b0, tx_shreg[7:1]};
              uart_txd <= tx_shreg[1];
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_STOP: begin
          if (tx_last) begin
            tx_cnt <= '0;
            if (tx_pop) begin
              tx_shreg <= fifo_rdata;
              uart_txd <= 1'b0;
              tx_state <= TX_START;
            end else begin
              tx_state <= TX_IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // ---------------- RX ----------------
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;

  logic [1:0]    rx_sync;
  logic          rxs;
  rx_state_t     rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shreg;
  logic          rx_done;
  logic          rx_last;
  logic          frame_evt;
  logic          overrun_evt;

  assign rxs         = rx_sync[1];
  assign rx_last     = (rx_cnt == CNT_LAST);
  assign frame_evt   = (rx_state == RX_STOP) && rx_last && !rxs;
  assign overrun_evt = rx_done && rx_valid && !rx_ack;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rx_sync <= 2'b11;
    else          rx_sync <= {rx_sync[0], uart_rxd};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shreg <= '0;
      rx_done  <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          rx_cnt <= '0;
          if (!rxs) rx_state <= RX_START;
        end
        RX_START: begin
          // A line that is high again at mid-start was only a glitch.
          if (rx_cnt == CNT_HALF) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rxs ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_last) begin
            rx_cnt   <= '0;
            rx_shreg <= {rxs, rx_shreg[7:1]};
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
            else                rx_bit   <= rx_bit + 1'b1;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_last) begin
            rx_cnt <= '0;
            if (rxs) begin
              rx_done  <= 1'b1;
              rx_state <= RX_IDLE;
            end else begin
              rx_state <= RX_BREAK;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_BREAK: begin
          if (rxs) rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_valid     <= 1'b0;
      rx_data      <= '0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      if (rx_done && (!rx_valid || rx_ack)) begin
        rx_data  <= rx_shreg;
        rx_valid <= 1'b1;
      end else if (rx_ack && rx_valid && !rx_done) begin
        rx_valid <= 1'b0;
      end
      if (overrun_evt)    rx_overrun <= 1'b1;
      else if (err_clear) rx_overrun <= 1'b0;
      if (frame_evt)      rx_frame_err <= 1'b1;
      else if (err_clear) rx_frame_err <= 1'b0;
    end
  end
endmodule

// File: tb/tb_sc64_uart_link.sv
// Scoreboard bench for sc64_uart_link at default parameters (DIV = 100).
`timescale 1ns/1ps

module tb_sc64_uart_link;
  localparam int DIV = 100;
  localparam int FRAME = 10 * DIV;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       rx_valid;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_overrun;
  logic       rx_frame_err;
  logic       err_clear;
  logic       uart_txd;
  logic       uart_rxd;
  logic       uart_cts_n;
  logic       uart_rts_n;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic frame_hit = 1'b0;

  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  int         tx_starts[$];

  sc64_uart_link dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .rx_valid    (rx_valid),
    .rx_ack      (rx_ack),
    .rx_data     (rx_data),
    .rx_overrun  (rx_overrun),
    .rx_frame_err(rx_frame_err),
    .err_clear   (err_clear),
    .uart_txd    (uart_txd),
    .uart_rxd    (uart_rxd),
    .uart_cts_n  (uart_cts_n),
    .uart_rts_n  (uart_rts_n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge reset_n) frame_hit = 1'b1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Offer one byte and hold it until accepted; waits = cycles spent stalled.
  task automatic push(input logic [7:0] b, output int acc, output int waits);
    waits = 0;
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = b;
    #1;
    while (!tx_ready && waits < 5000) begin
      @(negedge clk);
      #1;
      waits++;
    end
    if (waits >= 5000) check_val("push_timeout", 32'(waits), 32'd0);
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    acc = cyc;
    tx_q.push_back(b);
  endtask

  task automatic wait_idle(input int budget, output int fell);
    int n = 0;
    fell = -1;
    @(negedge clk);
    while (tx_busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!tx_busy) fell = cyc;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    @(negedge clk);
    uart_rxd = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (DIV) @(negedge clk);
    end
    uart_rxd = stop;
    repeat (DIV) @(negedge clk);
  endtask

  task automatic wait_rx(input int budget);
    int n = 0;
    while (!rx_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic pulse_ack();
    @(negedge clk);
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
  endtask

  // TX line monitor: decodes frames at mid-bit and scores them against tx_q.
  initial begin : tx_monitor
    int s;
    logic [7:0] b;
    logic st_ok;
    logic sp_ok;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && uart_txd === 1'b0) begin
        s = cyc;
        frame_hit = 1'b0;
        tx_starts.push_back(s);
        repeat (DIV / 2) @(negedge clk);
        st_ok = (uart_txd === 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          b[i] = uart_txd;
        end
        repeat (DIV) @(negedge clk);
        sp_ok = (uart_txd === 1'b1);
        if (!frame_hit) begin
          check_val("tx_start_bit", 32'(st_ok), 32'd1);
          check_val("tx_stop_bit", 32'(sp_ok), 32'd1);
          if (tx_q.size() == 0) check_val("tx_unexpected_frame", 32'(b), 32'hFFFF_FFFF);
          else                  check_val("tx_byte", 32'(b), 32'(tx_q.pop_front()));
        end
      end
    end
  end

  initial begin : main
    int a;
    int w;
    int fell;
    int n0;
    int stall_at;
    int lows;
    logic [7:0] burst [6];
    burst = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'h69, 8'h96};

    reset_n = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; rx_ack = 1'b0;
    err_clear = 1'b0; uart_rxd = 1'b1; uart_cts_n = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_tx_ready", 32'(tx_ready), 32'd1);
    check_val("rst_tx_busy", 32'(tx_busy), 32'd0);
    check_val("rst_rx_valid", 32'(rx_valid), 32'd0);
    check_val("rst_rx_data", 32'(rx_data), 32'd0);
    check_val("rst_overrun", 32'(rx_overrun), 32'd0);
    check_val("rst_frame_err", 32'(rx_frame_err), 32'd0);
    check_val("rst_txd", 32'(uart_txd), 32'd1);
    check_val("rst_rts_n", 32'(uart_rts_n), 32'd0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    // Single byte: start 1 cycle after accept, busy drops after the stop bit.
    push(8'hA5, a, w);
    wait_idle(3000, fell);
    check_val("tx_first_start", 32'(tx_starts[tx_starts.size() - 1]), 32'(a + 1));
    check_val("tx_busy_fall", 32'(fell), 32'(a + 1 + FRAME));

    // Leader occupies the shifter, so the 5th burst byte is the first to stall.
    n0 = tx_starts.size();
    push(8'h5A, a, w);
    repeat (2) @(negedge clk);
    stall_at = -1;
    for (int k = 0; k < 6; k++) begin
      push(burst[k], a, w);
      if (w > 0 && stall_at < 0) stall_at = k;
    end
    check_val("burst_stall_index", 32'(stall_at), 32'd4);
    wait_idle(12000, fell);
    check_val("burst_frames", 32'(tx_starts.size() - n0), 32'd7);
    for (int i = n0 + 1; i < tx_starts.size(); i++)
      check_val("b2b_gap", 32'(tx_starts[i] - tx_starts[i - 1]), 32'(FRAME));

    // RX: good frame, then overrun with the old data kept.
    send_frame(8'h3C, 1'b1);
    rx_q.push_back(8'h3C);
    wait_rx(300);
    check_val("rx_valid_first", 32'(rx_valid), 32'd1);
    check_val("rx_data_first", 32'(rx_data), 32'(rx_q.pop_front()));
    send_frame(8'h11, 1'b1);
    repeat (20) @(negedge clk);
    check_val("rx_overrun_set", 32'(rx_overrun), 32'd1);
    check_val("rx_data_kept", 32'(rx_data), 32'h3C);
    check_val("rx_valid_kept", 32'(rx_valid), 32'd1);
`ifdef UART_FLOW_CONTROL_EN
    check_val("rts_n_full", 32'(uart_rts_n), 32'd1);
`endif
    pulse_ack();
    check_val("rx_valid_acked", 32'(rx_valid), 32'd0);
    check_val("rx_overrun_sticky", 32'(rx_overrun), 32'd1);
    pulse_clear();
    check_val("rx_overrun_cleared", 32'(rx_overrun), 32'd0);

    send_frame(8'hC3, 1'b1);
    rx_q.push_back(8'hC3);
    wait_rx(300);
    check_val("rx_data_second", 32'(rx_data), 32'(rx_q.pop_front()));
    pulse_ack();

    // Stop bit low followed by a break, then a short glitch.
    send_frame(8'h55, 1'b0);
    repeat (200) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (20) @(negedge clk);
    check_val("frame_err_set", 32'(rx_frame_err), 32'd1);
    check_val("frame_err_no_byte", 32'(rx_valid), 32'd0);
    pulse_clear();
    check_val("frame_err_cleared", 32'(rx_frame_err), 32'd0);
    uart_rxd = 1'b0;
    repeat (30) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (1200) @(negedge clk);
    check_val("glitch_no_byte", 32'(rx_valid), 32'd0);
    check_val("glitch_no_frame_err", 32'(rx_frame_err), 32'd0);

    // Reset in the middle of data bit 3 (a 0 bit of 0xA5).
    push(8'hA5, a, w);
    push(8'h01, n0, w);
    push(8'h02, n0, w);
    while (cyc < a + 451) @(negedge clk);
    check_val("txd_bit3_low", 32'(uart_txd), 32'd0);
    #2 reset_n = 1'b0;
    #1 check_val("txd_async_reset", 32'(uart_txd), 32'd1);
    tx_q.delete();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_val("post_rst_tx_ready", 32'(tx_ready), 32'd1);
    check_val("post_rst_tx_busy", 32'(tx_busy), 32'd0);
    lows = 0;
    repeat (1200) begin
      @(negedge clk);
      if (uart_txd !== 1'b1) lows++;
    end
    check_val("post_rst_line_idle", 32'(lows), 32'd0);

`ifdef UART_FLOW_CONTROL_EN
    uart_cts_n = 1'b1;
    repeat (5) @(negedge clk);
    push(8'h81, a, w);
    repeat (300) @(negedge clk);
    check_val("cts_hold_txd", 32'(uart_txd), 32'd1);
    check_val("cts_hold_busy", 32'(tx_busy), 32'd1);
    n0 = tx_starts.size();
    uart_cts_n = 1'b0;
    lows = 0;
    while (tx_starts.size() == n0 && lows < 100) begin
      @(negedge clk);
      lows++;
    end
    check_val("cts_release_start", 32'(tx_starts.size() - n0), 32'd1);
    push(8'h42, a, w);
    while (cyc < tx_starts[n0] + 550) @(negedge clk);
    uart_cts_n = 1'b1;
    repeat (600) @(negedge clk);
    check_val("cts_frame_done", 32'(tx_q.size()), 32'd1);
    check_val("cts_next_held", 32'(uart_txd), 32'd1);
    uart_cts_n = 1'b0;
    wait_idle(3000, fell);
`endif

    repeat (10) @(negedge clk);
    check_val("tx_queue_drained", 32'(tx_q.size()), 32'd0);
    check_val("rx_queue_drained", 32'(rx_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
